psm_deadtime: RTL and testbench
===============================

Name: psm_deadtime

Overview:
- Dead-time inserter for one PSM/PWM phase leg.
- Takes a single-bit switching command and produces a complementary high-side/low-side gate pair.
- Inserts a programmable number of clock cycles where both outputs are off at every command transition.
- Sits between the PSM modulator and the gate-driver output pins.

Parameters:
- BITS_DATA, 8, width of the dead-time value in clock cycles (max dead time 2^BITS_DATA-1).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous active-low reset (RST=0 resets, release synchronous to CLK).
- iDEADTIME  input  BITS_DATA  dead time in CLK cycles, unsigned.
- iPSM  input  1  switching command (1 = high side on, 0 = low side on).
- oPSM  output  2  gate pair: [0] high side, [1] low side.

Behaviour:
- Interface (decided): one clock, CLK; reset RST, asynchronous, active-low.
- Reset:
  - oPSM=2'b00, state OFF, dead counter 0, held level 0.
  - Outputs are registered; no combinational path from iPSM to oPSM.
- States:
  - OFF (oPSM=00, counting down).
  - HIGH (oPSM=01).
  - LOW (oPSM=10).
- oPSM=2'b11 must never occur, in any state or cycle.
- Transition event: the rising edge E0 at which the sampled iPSM differs from the held level, or the first edge after reset release (treated as a transition to the current iPSM).
- Effect of a transition at E0:
  - Held level updates.
  - iDEADTIME is latched as D.
  - Later iDEADTIME changes do not affect this dead interval.
- D=0: at E0, oPSM switches directly to 01 (iPSM=1) or 10 (iPSM=0). Zero dead time, 1-cycle latency from iPSM.
- D>0:
  - At E0, oPSM=00 and state goes to OFF.
  - The new active output asserts at edge E0+D.
  - oPSM=00 therefore lasts exactly D cycles.
- Turn-off latency of the previously active side: 1 cycle (the E0 edge) in all cases.
- Retoggle during OFF: if iPSM changes again while counting, this is a new transition event. Counter reloads the current iPSM's D and outputs stay 00. Pulses shorter than D cycles are swallowed.
- Steady input: outputs hold indefinitely with no counter activity.
- Mid-operation reset: immediate oPSM=00. Resumes per the post-reset rule with a full dead interval.
- Arithmetic: counter is BITS_DATA wide, unsigned, and never wraps. It saturates at 0.

Optional Feature:
- Macro: PSM_DEADTIME_SYNC_EN.
- Defined:
  - iPSM passes through a 2-flop synchronizer (reset to 0) before edge detection.
  - Every latency above grows by 2 cycles. Dead duration is unchanged.
- Undefined: iPSM is sampled directly (caller guarantees it is synchronous to CLK).

Decomposition:
- Package psm_deadtime_pkg:
  - State encoding typedef: OFF, HIGH, LOW.
  - Output constants: OUT_OFF=2'b00, OUT_HIGH=2'b01, OUT_LOW=2'b10.
- One sub-module, psm_deadtime_counter: loadable, saturating down-counter of width BITS_DATA with a done flag.
- Top holds the edge detect, the optional synchronizer and the FSM.

Test Plan:
- Reset, D=1, iPSM=0, release RST → oPSM=00 for 1 cycle, then 10. Toggle iPSM to 1 → one cycle of 00, then 01.
- D=0, toggle iPSM every 10 cycles → oPSM flips 10↔01 with no 00 cycle, 1-cycle latency; never 11.
- D=5, iPSM 0→1 → 01 asserts exactly 5 cycles after the 00 starts. Change iDEADTIME to 2 during that interval → interval stays 5.
- D=5, 3-cycle iPSM pulse (0→1→0) → oPSM stays 00 for 5 cycles after the last change, then returns to 10. 01 never asserts.
- D=255 (max), long toggle period → exactly 255 dead cycles per edge, no counter wrap. Assert RST mid-dead-time → immediate 00, full dead interval after release.
- With PSM_DEADTIME_SYNC_EN, repeat the D=1 case → each edge response delayed 2 further cycles, dead interval unchanged. Assertion check throughout all cases: oPSM!=2'b11.

Source files
------------

// File: rtl/psm_deadtime_pkg.sv
// Shared types and output codes for the psm_deadtime dead-time inserter.
package psm_deadtime_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // oPSM bit 0 drives the high side, bit 1 the low side
    localparam logic [1:0] OUT_OFF  = 2'b00;
    localparam logic [1:0] OUT_HIGH = 2'b01;
    localparam logic [1:0] OUT_LOW  = 2'b10;

endpackage

// File: rtl/psm_deadtime_counter.sv
// Loadable down-counter that saturates at zero; done flags that the next decrement ends the interval.
module psm_deadtime_counter #(
    parameter int BITS_DATA = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [BITS_DATA-1:0] load_value,
    input  logic                 dec,
    output logic                 done
);

    logic [BITS_DATA-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // A loaded value of D releases the output on the D-th edge after the load
    assign done = (count_reg <= BITS_DATA'(1));

endmodule

// File: rtl/psm_deadtime.sv
// Dead-time inserter for one PSM/PWM phase leg: complementary gate pair with programmable off gap.
// Optional PSM_DEADTIME_SYNC_EN adds a 2-flop synchronizer on iPSM ahead of edge detection.
module psm_deadtime
    import psm_deadtime_pkg::*;
#(
    parameter int BITS_DATA = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BITS_DATA-1:0] iDEADTIME,
    input  logic                 iPSM,
    output logic [1:0]           oPSM
);

    logic psm_s;
    logic psm_valid;

`ifdef PSM_DEADTIME_SYNC_EN
    logic [1:0] sync_reg;
    logic [1:0] vld_reg;

    // vld_reg holds off the post-reset transition until real samples reach the FSM
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_reg <= '0;
            vld_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], iPSM};
            vld_reg  <= {vld_reg[0], 1'b1};
        end
    end

    assign psm_s     = sync_reg[1];
    assign psm_valid = vld_reg[1];
`else
    assign psm_s     = iPSM;
    assign psm_valid = 1'b1;
`endif

    state_t     state_reg;
    logic       held_reg;
    logic       started_reg;
    logic [1:0] out_reg;
    logic       transition;
    logic       zero_dead;
    logic       cnt_done;

    // The first valid sample after reset counts as a transition to that level
    assign transition = psm_valid && (!started_reg || (psm_s != held_reg));
    assign zero_dead  = (iDEADTIME == '0);

    psm_deadtime_counter #(
        .BITS_DATA (BITS_DATA)
    ) u_counter (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (transition),
        .load_value (iDEADTIME),
        .dec        (state_reg == OFF),
        .done       (cnt_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= OFF;
            held_reg    <= 1'b0;
            started_reg <= 1'b0;
            out_reg     <= OUT_OFF;
        end else if (transition) begin
            started_reg <= 1'b1;
            held_reg    <= psm_s;
            if (zero_dead) begin
                state_reg <= psm_s ? HIGH : LOW;
                out_reg   <= psm_s ? OUT_HIGH : OUT_LOW;
            end else begin
                state_reg <= OFF;
                out_reg   <= OUT_OFF;
            end
        end else if ((state_reg == OFF) && started_reg && cnt_done) begin
            state_reg <= held_reg ? HIGH : LOW;
            out_reg   <= held_reg ? OUT_HIGH : OUT_LOW;
        end
    end

    assign oPSM = out_reg;

endmodule

// File: tb/tb_psm_deadtime.sv
// Bench for psm_deadtime: vector table, dead-interval sequences and random toggling against a timestamp model.
module tb_psm_deadtime;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] iDEADTIME = 8'd0;
    logic       iPSM = 1'b0;
    logic [1:0] oPSM;

    int checks = 0;
    int errors = 0;

`ifdef PSM_DEADTIME_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    psm_deadtime #(.BITS_DATA(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iDEADTIME (iDEADTIME),
        .iPSM      (iPSM),
        .oPSM      (oPSM)
    );

    always #5 CLK = ~CLK;

    // Model: remember when the last transition event happened and its dead time
    bit         m_started = 1'b0;
    logic       m_level = 1'b0;
    int         m_cyc = 0;
    int         m_tev = 0;
    int         m_dev = 0;
    logic       m_p1 = 1'b0;
    logic       m_p2 = 1'b0;
    int         m_vld = 0;
    logic [1:0] m_exp = 2'b00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [7:0] d, input logic p);
        logic s;
        bit   v;
        if (!r) begin
            m_started = 1'b0;
            m_cyc = 0;
            m_p1 = 1'b0;
            m_p2 = 1'b0;
            m_vld = 0;
        end else begin
            m_cyc++;
`ifdef PSM_DEADTIME_SYNC_EN
            s = m_p2;
            v = (m_vld >= 2);
            m_p2 = m_p1;
            m_p1 = p;
            if (m_vld < 2) m_vld++;
`else
            s = p;
            v = 1'b1;
`endif
            if (v && (!m_started || (s != m_level))) begin
                m_started = 1'b1;
                m_level = s;
                m_tev = m_cyc;
                m_dev = int'(d);
            end
        end
        if (!m_started)
            m_exp = 2'b00;
        else if ((m_cyc - m_tev) >= m_dev)
            m_exp = m_level ? 2'b01 : 2'b10;
        else
            m_exp = 2'b00;
    endtask

    task automatic step(input logic r, input logic [7:0] d, input logic p);
        RST = r;
        iDEADTIME = d;
        iPSM = p;
        @(posedge CLK);
        model_edge(r, d, p);
        #1;
        $display("cyc=%0d rst=%0b d=%0d psm=%0b out=%b model=%b", m_cyc, r, d, p, oPSM, m_exp);
        check("model", int'(oPSM), int'(m_exp));
    endtask

    // The gate pair must never have both sides on
    always @(negedge CLK) begin
        checks++;
        if (oPSM == 2'b11) begin
            errors++;
            $display("FAIL shoot_through at t=%0t: got oPSM=%b, expected not 11", $time, oPSM);
        end
    end

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       psm;
        logic [1:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] d, input logic p, input logic [1:0] e);
        vec_t v;
        v.rst = r; v.d = d; v.psm = p; v.exp = e;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        logic p;
        logic [7:0] d;

        // Reset, D=1, release, toggle high
        add(0, 1, 0, 2'b00);
        add(1, 1, 0, 2'b00);
        add(1, 1, 0, 2'b10);
        add(1, 1, 0, 2'b10);
        add(1, 1, 1, 2'b00);
        add(1, 1, 1, 2'b01);
        add(1, 1, 1, 2'b01);
        // D=0: direct flip, no off cycle
        add(1, 0, 0, 2'b10);
        add(1, 0, 0, 2'b10);
        add(1, 0, 1, 2'b01);
        add(1, 0, 0, 2'b10);
        add(1, 0, 0, 2'b10);
        // D=5, then iDEADTIME changed to 2 during the interval
        add(1, 5, 1, 2'b00);
        for (int i = 0; i < 4; i++) add(1, 2, 1, 2'b00);
        add(1, 2, 1, 2'b01);
        // D=5, 3-cycle pulse is swallowed
        add(1, 5, 0, 2'b00);
        for (int i = 0; i < 3; i++) add(1, 5, 1, 2'b00);
        for (int i = 0; i < 5; i++) add(1, 5, 0, 2'b00);
        add(1, 5, 0, 2'b10);
        add(1, 5, 0, 2'b10);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].d, tbl[i].psm);
`ifndef PSM_DEADTIME_SYNC_EN
            check($sformatf("vec%0d", i), int'(oPSM), int'(tbl[i].exp));
`endif
        end

        // Maximum dead time from a steady LOW state
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 255, 1);
            if (oPSM == 2'b00) n++;
            else if (n > 0) break;
        end
        check("dead255_len", n, 255);
        check("dead255_after", int'(oPSM), 1);

        // Reset in the middle of a 255-cycle dead interval
        for (int i = 0; i < 100; i++) step(1, 255, 0);
        RST = 1'b0;
        #1;
        check("rst_immediate", int'(oPSM), 0);
        step(0, 255, 0);
        step(0, 255, 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 255, 0);
            if (oPSM == 2'b00) n++;
            else break;
        end
        check("rst_dead_len", n, 255 + LAT);
        check("rst_dead_after", int'(oPSM), 2);

        // Random toggling with occasional resets and dead-time changes
        p = 1'b0;
        d = 8'd3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) d = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) p = ~p;
            if ($urandom_range(0, 299) == 0) begin
                step(0, d, p);
                step(0, d, p);
            end else begin
                step(1, d, p);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
